// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared op/state encodings and decode helpers for muldiv_ctrl
// Purpose: op encoding, FSM state codes, divider step count, op decode helpers.
// Ports: none (package).
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  // State codes kept as plain constants so older blocks can compare raw bits.
  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t ST_IDLE = 2'd0;
  localparam muldiv_state_t ST_MUL  = 2'd1;
  localparam muldiv_state_t ST_DIV  = 2'd2;
  localparam muldiv_state_t ST_SIGN = 2'd3;

  // One quotient bit per step; tied to the 32-bit data width.
  localparam int DIV_STEPS = 32;

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// rtl/muldiv_ctrl_div_iter.sv - restoring divider datapath, one quotient bit per step
// Purpose: unsigned 32/32 restoring division on magnitudes; sequencing lives in muldiv_ctrl.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              capture dividend/divisor (starts a new division)
//   preset            with load: skip iteration, present the divide-by-zero result directly
//   step              perform one restoring step (MSB first)
//   dividend, divisor unsigned operands
//   quotient, remainder  current quotient/remainder registers
module div_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        preset,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dsr_q;
  logic [32:0] shifted;
  logic [31:0] sub;
  logic        ge;

  // The dividend is consumed from the top of the quotient register while
  // quotient bits fill in from the bottom.
  assign shifted = {rem_q, quo_q[31]};
  assign ge      = shifted >= {1'b0, dsr_q};
  // When ge holds the true difference is below the divisor, so 32 bits suffice.
  assign sub     = shifted[31:0] - dsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      dsr_q <= divisor;
      if (preset) begin
        quo_q <= '1;
        rem_q <= dividend;
      end else begin
        quo_q <= dividend;
        rem_q <= '0;
      end
    end else if (step) begin
      if (ge) begin
        rem_q <= sub;
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle multiply/divide sequencer owning HI/LO
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, sequences multiplier and divider,
//          writes HI/LO, raises busy while an op is in flight.
// Optional build macro: MULDIV_ZERO_EXIT_EN (divide by zero bypasses the 32 steps).
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   req_valid/req_ready           op handshake (ready only in IDLE)
//   req_op, req_a, req_b          op code and rs/rt operands
//   flush                         abort any in-flight op, block acceptance
//   hi, lo                        architectural HI/LO registers
//   busy                          op in flight
//   done                          one-cycle pulse when new HI/LO become visible
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  muldiv_state_t state;
  logic [31:0]   cnt;
  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          q_neg_q;
  logic          r_neg_q;

  logic          fire;
  logic          zero_exit;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   quo;
  logic [31:0]   rem;
  logic [63:0]   mul_a;
  logic [63:0]   mul_b;
  logic [63:0]   product;
  logic          last_mul;
  logic          wr_mt;
  logic          wr_mul;
  logic          wr_sign;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign fire      = req_valid && req_ready && !flush;

  // DIVU divides raw operands; DIV divides magnitudes and fixes signs in SIGN.
  assign a_mag = (is_signed(req_op) && req_a[31]) ? -req_a : req_a;
  assign b_mag = (is_signed(req_op) && req_b[31]) ? -req_b : req_b;

`ifdef MULDIV_ZERO_EXIT_EN
  assign zero_exit = is_div(req_op) && (req_b == '0);
`else
  assign zero_exit = 1'b0;
`endif

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (reset),
    .load      (fire && is_div(req_op)),
    .preset    (zero_exit),
    .step      (state == ST_DIV),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
  assign mul_a   = {{32{is_signed(op_q) & a_q[31]}}, a_q};
  assign mul_b   = {{32{is_signed(op_q) & b_q[31]}}, b_q};
  assign product = mul_a * mul_b;

  assign last_mul = (state == ST_MUL) && (cnt == 32'(MUL_LAT - 1));
  assign wr_mt    = fire && ((req_op == OP_MTHI) || (req_op == OP_MTLO));
  // A flush in the write cycle suppresses the write.
  assign wr_mul   = last_mul && !flush;
  assign wr_sign  = (state == ST_SIGN) && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= wr_mt | wr_mul | wr_sign;
      if (flush) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (fire) begin
              op_q    <= req_op;
              a_q     <= req_a;
              b_q     <= req_b;
              cnt     <= '0;
              q_neg_q <= is_signed(req_op) && (req_a[31] ^ req_b[31]);
              r_neg_q <= is_signed(req_op) && req_a[31];
              case (req_op)
                OP_MTHI:           hi    <= req_a;
                OP_MTLO:           lo    <= req_a;
                OP_MULT, OP_MULTU: state <= ST_MUL;
                OP_DIV, OP_DIVU:   state <= zero_exit ? ST_SIGN : ST_DIV;
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            if (last_mul) begin
              {hi, lo} <= product;
              state    <= ST_IDLE;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          ST_DIV: begin
            if (cnt == 32'(DIV_STEPS - 1)) begin
              state <= ST_SIGN;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          default: begin
            lo    <= q_neg_q ? -quo : quo;
            hi    <= r_neg_q ? -rem : rem;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
